mux8_byte_sequencer: RTL and testbench

//  Upstream controller for the 8:1 byte mux (mux8_1_8bit). On a start pulse it walks sel

---
 rtl/mux8_byte_sequencer_pkg.sv | 17 +
 rtl/byte_xor_acc.sv | 24 ++
 rtl/mux8_1_8bit.sv | 37 +++
 rtl/mux8_byte_sequencer.sv | 156 +++++++++++++++
 tb/tb_mux8_byte_sequencer.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mux8_byte_sequencer_pkg.sv
// Shared definitions for the mux8 byte sequencer: FSM encodings,
// default frame size and the length-field width.
package mopshub_seq_pkg;

    localparam int MAX_BYTES_DEF = 8;
    localparam int LEN_W         = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEL,
        ST_CAP,
        ST_SEND,
        ST_CHK,
        ST_DONE
    } seq_state_t;

endpackage

// File: rtl/byte_xor_acc.sv
// Running XOR of accepted bytes; clear has priority over enable.
// Ports: clk, rst (async active-low), clear, enable, din[W], acc[W].
module byte_xor_acc #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] din,
    output logic [W-1:0] acc
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (enable) begin
            acc <= acc ^ din;
        end
    end

endmodule

// File: rtl/mux8_1_8bit.sv
// Registered 8:1 byte mux loaded when en_sel is high.
// Ports: clk, rst (async active-low), sel[8], en_sel, data0..7[8], mux_out[8].
module mux8_1_8bit (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sel,
    input  logic       en_sel,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    input  logic [7:0] data2,
    input  logic [7:0] data3,
    input  logic [7:0] data4,
    input  logic [7:0] data5,
    input  logic [7:0] data6,
    input  logic [7:0] data7,
    output logic [7:0] mux_out
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mux_out <= '0;
        end else if (en_sel) begin
            case (sel)
                8'd0:    mux_out <= data0;
                8'd1:    mux_out <= data1;
                8'd2:    mux_out <= data2;
                8'd3:    mux_out <= data3;
                8'd4:    mux_out <= data4;
                8'd5:    mux_out <= data5;
                8'd6:    mux_out <= data6;
                8'd7:    mux_out <= data7;
                default: mux_out <= '0;
            endcase
        end
    end

endmodule

// File: rtl/mux8_byte_sequencer.sv
// Walks the 8:1 byte mux through 0..len-1 and streams the captured
// bytes out over valid/ready. Optional XOR checksum byte appended when
// MUX8_SEQ_CHECKSUM_EN is defined.
// Ports: clk, rst (async active-low), start, len[4], abort,
//        sel[SEL_W], en_sel, mux_data[DATA_W],
//        tx_data[DATA_W], tx_valid, tx_ready, tx_last, busy, done.
module mux8_byte_sequencer
    import mopshub_seq_pkg::*;
#(
    parameter int MAX_BYTES = MAX_BYTES_DEF,
    parameter int SEL_W     = 8,
    parameter int DATA_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              abort,
    output logic [SEL_W-1:0]  sel,
    output logic              en_sel,
    input  logic [DATA_W-1:0] mux_data,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              tx_last,
    output logic              busy,
    output logic              done
);

    seq_state_t       state;
    logic [LEN_W-1:0] idx;
    logic [LEN_W-1:0] len_r;
    logic [LEN_W-1:0] len_clamp;
    logic             last;
    logic             xfer;

    assign len_clamp = (len > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : len;
    assign last      = (idx == len_r - 1'b1);
    assign xfer      = tx_valid & tx_ready;

`ifdef MUX8_SEQ_CHECKSUM_EN
    logic [DATA_W-1:0] acc;
    logic              acc_clr;
    logic              acc_en;

    assign acc_clr = (state == ST_IDLE) & start & ~abort;
    assign acc_en  = (state == ST_SEND) & xfer & ~abort;

    byte_xor_acc #(.W(DATA_W)) u_acc (
        .clk    (clk),
        .rst    (rst),
        .clear  (acc_clr),
        .enable (acc_en),
        .din    (tx_data),
        .acc    (acc)
    );
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            idx      <= '0;
            len_r    <= '0;
            sel      <= '0;
            en_sel   <= 1'b0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            tx_last  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else if (abort && state != ST_IDLE) begin
            // Frame dropped: byte in flight discarded, no done pulse.
            state    <= ST_IDLE;
            en_sel   <= 1'b0;
            tx_valid <= 1'b0;
            tx_last  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start && !abort) begin
                        len_r <= len_clamp;
                        idx   <= '0;
                        busy  <= 1'b1;
                        if (len_clamp == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state  <= ST_SEL;
                            sel    <= '0;
                            en_sel <= 1'b1;
                        end
                    end
                end
                ST_SEL: begin
                    // Mux loads data[idx] on this edge.
                    en_sel <= 1'b0;
                    state  <= ST_CAP;
                end
                ST_CAP: begin
                    tx_data  <= mux_data;
                    tx_valid <= 1'b1;
`ifdef MUX8_SEQ_CHECKSUM_EN
                    tx_last  <= 1'b0;
`else
                    tx_last  <= last;
`endif
                    state    <= ST_SEND;
                end
                ST_SEND: begin
                    if (xfer) begin
                        if (last) begin
`ifdef MUX8_SEQ_CHECKSUM_EN
                            // acc has not yet absorbed the final byte.
                            tx_data <= acc ^ tx_data;
                            tx_last <= 1'b1;
                            state   <= ST_CHK;
`else
                            tx_valid <= 1'b0;
                            tx_last  <= 1'b0;
                            done     <= 1'b1;
                            state    <= ST_DONE;
`endif
                        end else begin
                            tx_valid <= 1'b0;
                            tx_last  <= 1'b0;
                            idx      <= idx + 1'b1;
                            sel      <= SEL_W'(idx + 1'b1);
                            en_sel   <= 1'b1;
                            state    <= ST_SEL;
                        end
                    end
                end
                ST_CHK: begin
                    if (xfer) begin
                        tx_valid <= 1'b0;
                        tx_last  <= 1'b0;
                        done     <= 1'b1;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux8_byte_sequencer.sv
// Directed bench for mux8_byte_sequencer driving a mux8_1_8bit.
// Works with or without MUX8_SEQ_CHECKSUM_EN.
module tb_mux8_byte_sequencer;

`ifdef MUX8_SEQ_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] len;
    logic       abort;
    logic [7:0] sel;
    logic       en_sel;
    logic [7:0] mux_data;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_last;
    logic       busy;
    logic       done;
    logic [7:0] d [8];

    int n_cmp;
    int n_err;

    logic [7:0] got [$];
    logic       lastv [$];
    int         first_valid;
    int         t_done;
    int         t_lastx;
    int         max_sel;
    int         n_en;
    int         held;

    mux8_byte_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .len      (len),
        .abort    (abort),
        .sel      (sel),
        .en_sel   (en_sel),
        .mux_data (mux_data),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_last  (tx_last),
        .busy     (busy),
        .done     (done)
    );

    mux8_1_8bit u_mux (
        .clk     (clk),
        .rst     (rst),
        .sel     (sel),
        .en_sel  (en_sel),
        .data0   (d[0]),
        .data1   (d[1]),
        .data2   (d[2]),
        .data3   (d[3]),
        .data4   (d[4]),
        .data5   (d[5]),
        .data6   (d[6]),
        .data7   (d[7]),
        .mux_out (mux_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_start(input logic [3:0] l);
        start = 1'b1;
        len   = l;
        tick();
        start = 1'b0;
    endtask

    // Runs the stream with tx_ready=1 except st_n stall cycles on byte st_idx.
    task automatic collect(input int budget, input int st_idx, input int st_n);
        int  stalled;
        bit  fin;
        got.delete();
        lastv.delete();
        first_valid = -1;
        t_done      = -1;
        t_lastx     = -1;
        max_sel     = 0;
        n_en        = 0;
        held        = 0;
        stalled     = 0;
        fin         = 1'b0;
        for (int k = 1; k <= budget && !fin; k++) begin
            if (en_sel) begin
                n_en++;
                if (int'(sel) > max_sel) max_sel = int'(sel);
            end
            if (tx_valid && first_valid < 0) first_valid = k;
            if (done) begin
                t_done = k;
                fin    = 1'b1;
            end
            tx_ready = 1'b1;
            if (tx_valid && got.size() == st_idx && stalled < st_n) begin
                tx_ready = 1'b0;
                stalled++;
                if (tx_data == 8'(8'h10 + st_idx)) held++;
            end
            if (tx_valid && tx_ready) begin
                got.push_back(tx_data);
                lastv.push_back(tx_last);
                t_lastx = k;
            end
            if (!fin) tick();
        end
        chk("frame_timeout", 32'(fin), 32'd1);
    endtask

    task automatic chk_stream(input string tag, input int nbytes);
        chk({tag, "_size"}, 32'(got.size()), 32'(nbytes + CK));
        for (int i = 0; i < nbytes && i < got.size(); i++) begin
            chk({tag, "_byte"}, 32'(got[i]), 32'(8'(8'h10 + i)));
        end
        for (int i = 0; i < got.size(); i++) begin
            chk({tag, "_last"}, 32'(lastv[i]),
                32'(i == nbytes + CK - 1));
        end
    endtask

    initial begin
        bit hit;
        n_cmp    = 0;
        n_err    = 0;
        rst      = 1'b0;
        start    = 1'b0;
        len      = 4'd0;
        abort    = 1'b0;
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) d[i] = 8'(8'h10 + i);
        #2;
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_en_sel", 32'(en_sel), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_last", 32'(tx_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // 1: full 8-byte frame, no stalls
        send_start(4'd8);
        chk("t1_busy", 32'(busy), 32'd1);
        collect(100, -1, 0);
        chk("t1_first_valid", 32'(first_valid), 32'd3);
        chk_stream("t1", 8);
        chk("t1_done_lat", 32'(t_done), 32'(t_lastx + 1));
        chk("t1_n_en", 32'(n_en), 32'd8);
        tick();
        chk("t1_done_clr", 32'(done), 32'd0);
        chk("t1_busy_clr", 32'(busy), 32'd0);

        // 2: len=3, byte 1 stalled 5 cycles
        send_start(4'd3);
        collect(100, 1, 5);
        chk_stream("t2", 3);
        chk("t2_held", 32'(held), 32'd5);
        chk("t2_n_en", 32'(n_en), 32'd3);
        tick();

        // 3a: len=0, no bytes, done right away
        send_start(4'd0);
        collect(20, -1, 0);
        chk("t3_size", 32'(got.size()), 32'd0);
        chk("t3_no_valid", 32'(first_valid), 32'hffffffff);
        chk("t3_done_at", 32'(t_done), 32'd1);
        tick();
        chk("t3_busy_clr", 32'(busy), 32'd0);

        // 3b: len=12 clamped to 8
        send_start(4'd12);
        collect(100, -1, 0);
        chk_stream("t3b", 8);
        chk("t3b_max_sel", 32'(max_sel), 32'd7);
        chk("t3b_n_en", 32'(n_en), 32'd8);
        tick();

        // 4: abort while byte 4 is presented
        send_start(4'd8);
        hit = 1'b0;
        for (int k = 0; k < 60 && !hit; k++) begin
            tx_ready = 1'b1;
            if (tx_valid && tx_data == 8'h14) begin
                hit   = 1'b1;
                abort = 1'b1;
            end else begin
                tick();
            end
        end
        chk("t4_reach_b4", 32'(hit), 32'd1);
        tick();
        abort = 1'b0;
        chk("t4_valid", 32'(tx_valid), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_done", 32'(done), 32'd0);
        hit = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (done || tx_valid) hit = 1'b1;
            tick();
        end
        chk("t4_quiet", 32'(hit), 32'd0);
        send_start(4'd8);
        collect(100, -1, 0);
        chk_stream("t4_resend", 8);
        tick();

        // 5: reset mid-frame, then start while busy
        send_start(4'd8);
        hit = 1'b0;
        for (int k = 0; k < 60 && !hit; k++) begin
            if (tx_valid && tx_data == 8'h12) hit = 1'b1;
            else tick();
        end
        chk("t5_reach_b2", 32'(hit), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("t5_sel", 32'(sel), 32'd0);
        chk("t5_tx_data", 32'(tx_data), 32'd0);
        chk("t5_tx_valid", 32'(tx_valid), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        send_start(4'd3);
        tick();
        start = 1'b1;
        len   = 4'd8;
        tick();
        start = 1'b0;
        collect(100, -1, 0);
        chk_stream("t5_busy_start", 3);
        tick();

        // 6: 01,02,04 (+07 checksum when enabled)
        d[0] = 8'h01;
        d[1] = 8'h02;
        d[2] = 8'h04;
        send_start(4'd3);
        collect(100, -1, 0);
        chk("t6_size", 32'(got.size()), 32'(3 + CK));
        if (got.size() >= 3) begin
            chk("t6_b0", 32'(got[0]), 32'h01);
            chk("t6_b1", 32'(got[1]), 32'h02);
            chk("t6_b2", 32'(got[2]), 32'h04);
        end
`ifdef MUX8_SEQ_CHECKSUM_EN
        if (got.size() >= 4) chk("t6_ck", 32'(got[3]), 32'h07);
`endif
        for (int i = 0; i < got.size(); i++) begin
            chk("t6_last", 32'(lastv[i]), 32'(i == 2 + CK));
        end
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
